mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch port (IF stage, read-only) and the data port (MEM stage, read/write).
- Sequences each memory access with a FSM, holds the address and data stable until the memory signals ready, and aborts accesses that exceed a timeout.
- Produces a stall signal that the pipeline top level uses to gate the PC enable (pcen = ~stall) and to freeze the pipeline registers.

Parameters:
- WIDTH, 32: data and address width.
- TIMEOUT, 16: maximum number of ACC cycles to wait for mem_ready before aborting; legal range 2..255.
- MAX_DBURST, 4: maximum consecutive data grants while a fetch waits. Used only when ARB_FAIR_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  WIDTH  fetch address
- if_rdata  out  WIDTH  fetched word; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WIDTH  data address
- d_wdata  in  WIDTH  write data
- d_rdata  out  WIDTH  read data; valid while d_ack=1 and the access was a read
- d_ack  out  1  one-cycle completion pulse for data
- err  out  1  high together with the ack when the access timed out
- mem_req  out  1  level request to memory; high for the whole ACC state
- mem_we  out  1  write strobe qualifier to memory
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completion
- stall  out  1  pipeline stall

Interface:
- Reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: state=IDLE; if_ack, d_ack, err, mem_req, mem_we = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- FSM states: IDLE, IF_ACC, D_ACC, RESP.
  - IDLE: if d_req=1, latch d_addr/d_wdata/d_we into mem_* and go to D_ACC. Else if if_req=1, latch if_addr, set mem_we=0 and go to IF_ACC. Else stay.
  - Simultaneous requests in IDLE: data wins, because it belongs to the older instruction.
  - IF_ACC / D_ACC: mem_req=1 and the mem_* outputs stay stable.
    - mem_ready=1: capture mem_rdata into the owner's rdata (reads only; d_rdata is unchanged on a write) and go to RESP.
    - Timeout counter reaches TIMEOUT-1 without mem_ready: set err and go to RESP; the owner's rdata is forced to 0.
  - RESP: assert the owner's ack (plus err if it was set) for exactly one cycle, mem_req=0, then go to IDLE. err clears on leaving RESP.
- Latency: req sampled in IDLE at cycle 0; ACC state from cycle 1; mem_ready at cycle k≥1; ack at cycle k+1. A zero-wait memory gives ack at cycle 2.
- Requester rules:
  - req, addr, we and wdata must stay stable from assertion until the ack cycle.
  - req still high in the cycle after ack (IDLE) is treated as a new request.
  - req sampled during RESP is ignored.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack). This is combinational from registered acks, so it has no loop through memory.
- Timeout counter: cleared on entry to any ACC state. Width is ceil(log2(TIMEOUT))+1.
- mem_ready while in IDLE or RESP is ignored (spurious ready).
- Reset mid-access: mem_req drops asynchronously, no ack is issued, and the in-flight access is lost. Requesters re-issue after reset.
- At most one memory access is outstanding at any time.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A counter dburst increments on each data grant issued while if_req=1, and clears on any fetch grant.
  - When dburst == MAX_DBURST and both requests are present in IDLE, the fetch is granted instead.
  - Reset value of dburst is 0.
- Undefined: strict data priority and no counter logic.

Decomposition:
- Package mips_arb_pkg holds:
  - arb_state_t enum (IDLE, IF_ACC, D_ACC, RESP), 2 bits.
  - Owner encoding: OWN_IF=0, OWN_D=1.
  - ERR_RDATA = 0.
- One sub-module, arb_timeout_counter: clear/enable inputs and an expired output, parameterized by TIMEOUT.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10; memory ready at first ACC cycle with rdata=0x8C080004 -> if_ack at cycle 2, if_rdata=0x8C080004, stall=1 during cycles 0-1.
- Conflict: if_req and d_req both high (d_we=1, addr=0x40, wdata=0xA5A5A5A5) -> data served first, mem_we=1 with mem_addr=0x40; fetch is served after d_ack; total of 2 acks, in order d then if.
- Wait states: memory ready after 5 cycles on a data read of 0x20 -> d_ack at cycle 6; mem_addr stays 0x20 throughout; d_rdata equals mem_rdata.
- Timeout: TIMEOUT=16 and mem_ready never asserted -> d_ack with err=1 at cycle 17; d_rdata=0; next request proceeds normally.
- Reset mid-access: assert rst in D_ACC -> mem_req=0 immediately, no ack; after release the state is IDLE and all outputs are 0.
- ARB_FAIR_EN with MAX_DBURST=4: d_req and if_req held continuously -> grant order D,D,D,D,IF,D...; without the macro, IF is never granted while d_req stays high.

Source files
------------

// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles spent in an access state; expired is high on the last allowed cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Cycle counter, saturating so a stuck enable can never wrap past the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != LAST_C)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (cnt_r == LAST_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data ports.
// Define ARB_FAIR_EN to bound consecutive data grants while a fetch is waiting.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_DBURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall
);

  arb_state_t       state_r, state_next_s;
  logic             owner_r;
  logic             if_ack_r, d_ack_r, err_r, mem_req_r, mem_we_r;
  logic [WIDTH-1:0] mem_addr_r, mem_wdata_r, if_rdata_r, d_rdata_r;
  logic             grant_d_s, grant_if_s, done_ok_s, done_to_s;
  logic             in_acc_s, expired_s, fetch_pref_s;

  assign in_acc_s = (state_r == IF_ACC) || (state_r == D_ACC);

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_d_s | grant_if_s),
    .en      (in_acc_s),
    .expired (expired_s)
  );

`ifdef ARB_FAIR_EN
  localparam int DBW = $clog2(MAX_DBURST + 1);
  logic [DBW-1:0] dburst_r;

  // Data grants issued while a fetch waits; a fetch grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dburst_r <= {DBW{1'b0}};
    end else if (grant_if_s) begin
      dburst_r <= {DBW{1'b0}};
    end else if (grant_d_s && if_req) begin
      dburst_r <= dburst_r + {{(DBW-1){1'b0}}, 1'b1};
    end
  end

  assign fetch_pref_s = if_req && (dburst_r == DBW'(MAX_DBURST));
`else
  assign fetch_pref_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, grant and completion decode; data wins ties unless fairness forces a fetch.
  always_comb begin
    state_next_s = state_r;
    grant_d_s    = 1'b0;
    grant_if_s   = 1'b0;
    done_ok_s    = 1'b0;
    done_to_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_req && !fetch_pref_s) begin
          grant_d_s    = 1'b1;
          state_next_s = D_ACC;
        end else if (if_req) begin
          grant_if_s   = 1'b1;
          state_next_s = IF_ACC;
        end else begin
          state_next_s = IDLE;
        end
      end
      IF_ACC, D_ACC: begin
        if (mem_ready) begin
          done_ok_s    = 1'b1;
          state_next_s = RESP;
        end else if (expired_s) begin
          done_to_s    = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = state_r;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Registered memory-side and requester-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r     <= OWN_IF;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {WIDTH{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
      if_rdata_r  <= {WIDTH{1'b0}};
      d_rdata_r   <= {WIDTH{1'b0}};
    end else begin
      mem_req_r <= (state_next_s == IF_ACC) || (state_next_s == D_ACC);
      if_ack_r  <= (done_ok_s || done_to_s) && (owner_r == OWN_IF);
      d_ack_r   <= (done_ok_s || done_to_s) && (owner_r == OWN_D);
      err_r     <= done_to_s;
      if (grant_d_s) begin
        owner_r     <= OWN_D;
        mem_addr_r  <= d_addr;
        mem_wdata_r <= d_wdata;
        mem_we_r    <= d_we;
      end else if (grant_if_s) begin
        owner_r    <= OWN_IF;
        mem_addr_r <= if_addr;
        mem_we_r   <= 1'b0;
      end
      if (done_ok_s) begin
        if (owner_r == OWN_IF) begin
          if_rdata_r <= mem_rdata;
        end else if (!mem_we_r) begin
          d_rdata_r <= mem_rdata;
        end
      end else if (done_to_s) begin
        if (owner_r == OWN_IF) begin
          if_rdata_r <= WIDTH'(ERR_RDATA);
        end else begin
          d_rdata_r <= WIDTH'(ERR_RDATA);
        end
      end
    end
  end

  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign err       = err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign stall     = (if_req & ~if_ack_r) | (d_req & ~d_ack_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=16, MAX_DBURST=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, err, mem_req, mem_we, stall;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(16), .MAX_DBURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({if_ack, d_ack, err, mem_we} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {if_ack, d_ack, err, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h8C08_0004; mem_ready = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_c0: got %b want 1", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_req_c0: got %b want 0", mem_req); end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_acc_c1: got req=%b addr=%h we=%b want 1/00000010/0", mem_req, mem_addr, mem_we); end
    n_cmp++; if (stall !== 1'b1 || if_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_c1: got stall=%b ack=%b want 1/0", stall, if_ack); end
    @(negedge clk);
    n_cmp++; if (if_ack !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL fetch_ack_c2: got ack=%b err=%b want 1/0", if_ack, err); end
    n_cmp++; if (if_rdata !== 32'h8C08_0004) begin n_bad++; $display("FAIL fetch_rdata: got %h want 8c080004", if_rdata); end
    n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_c2_misc: got stall=%b req=%b dack=%b want 0/0/0", stall, mem_req, d_ack); end
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_c3_idle: got ack=%b req=%b want 0/0", if_ack, mem_req); end
  endtask

  task automatic test_conflict;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5;
    mem_rdata = 32'h1234_5678; mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL conflict_d_first: got req=%b we=%b addr=%h wd=%h want 1/1/40/a5a5a5a5", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin n_bad++; $display("FAIL conflict_ack1: got d=%b if=%b want 1/0", d_ack, if_ack); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL conflict_write_rdata: got %h want 0", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL conflict_idle: got req=%b if=%b d=%b want 0/0/0", mem_req, if_ack, d_ack); end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin n_bad++; $display("FAIL conflict_if_acc: got req=%b addr=%h we=%b want 1/80/0", mem_req, mem_addr, mem_we); end
    @(negedge clk);
    n_cmp++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL conflict_ack2: got if=%b d=%b rd=%h want 1/0/12345678", if_ack, d_ack, if_rdata); end
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || d_ack !== 1'b0) begin n_bad++; $display("FAIL wait_hold_c%0d: got req=%b addr=%h ack=%b want 1/20/0", c, mem_req, mem_addr, d_ack); end
      if (c == 5) mem_ready = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wait_ack_c6: got ack=%b err=%b rd=%h want 1/0/deadbeef", d_ack, err, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1 || d_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL timeout_wait_c%0d: got req=%b ack=%b err=%b want 1/0/0", c, mem_req, d_ack, err); end
    end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_ack_c17: got ack=%b err=%b rd=%h req=%b want 1/1/0/0", d_ack, err, d_rdata, mem_req); end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got err=%b ack=%b want 0/0", err, d_ack); end
    d_req = 1'b1; d_addr = 32'h34; mem_rdata = 32'h0BAD_F00D; mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h34) begin n_bad++; $display("FAIL timeout_next_acc: got req=%b addr=%h want 1/34", mem_req, mem_addr); end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL timeout_next_ack: got ack=%b err=%b rd=%h want 1/0/0badf00d", d_ack, err, d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h5555_AAAA; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_acc: got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_drop: got req=%b ack=%b want 0/0", mem_req, d_ack); end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_req, mem_we, if_ack, d_ack, err, stall} !== 6'b0) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000000", {mem_req, mem_we, if_ack, d_ack, err, stall}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin n_bad++; $display("FAIL rstmid_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    repeat (2) @(negedge clk);
    n_cmp++; if (d_ack !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_ack: got ack=%b req=%b want 0/0", d_ack, mem_req); end
  endtask

  task automatic test_grant_order;
    logic [5:0] got_d;
    logic [5:0] exp_d;
    int g;
`ifdef ARB_FAIR_EN
    exp_d = 6'b101111;
`else
    exp_d = 6'b111111;
`endif
    got_d = 6'b000000;
    g = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    if_req = 1'b1; if_addr = 32'h90;
    mem_rdata = 32'h0000_0001; mem_ready = 1'b1;
    for (int c = 0; c < 40 && g < 6; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        got_d[g] = (mem_addr === 32'h60);
        g++;
      end
    end
    n_cmp++; if (g != 6) begin n_bad++; $display("FAIL order_grant_count: got %0d want 6", g); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (got_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL order_grant%0d: got is_data=%b want %b", i, got_d[i], exp_d[i]); end
    end
    d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_grant_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
